seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 202 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with single-cycle logic/arith ops and iterative MUL/DIV
module seq_alu #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  out_hi,
  output logic              flag
);

  localparam logic [FUNC_W-1:0] OP_PLUS  = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] OP_MINUS = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] OP_MUL   = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] OP_DIV   = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] OP_AND   = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] OP_OR    = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] OP_XOR   = FUNC_W'(6);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Captured request and iteration state
  logic             op_mul;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [CW-1:0]    cnt;

  logic accept;
  logic last_iter;
  logic is_iter_op;

  assign accept     = in_valid && in_ready;
  assign last_iter  = (cnt == LAST);
  assign is_iter_op = (func == OP_MUL) || (func == OP_DIV);

  // Single-cycle results, computed straight from the inputs at acceptance
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] short_out;
  logic             short_flag;

  // Combinational result for the one-cycle opcodes; undefined codes give zero
  always_comb begin
    add_full   = {1'b0, a} + {1'b0, b};
    sub_full   = {1'b0, a} - {1'b0, b};
    short_out  = '0;
    short_flag = 1'b0;
    case (func)
      OP_PLUS: begin
        short_out  = add_full[WIDTH-1:0];
        short_flag = add_full[WIDTH];
      end
      OP_MINUS: begin
        short_out  = sub_full[WIDTH-1:0];
        short_flag = sub_full[WIDTH];
      end
      OP_AND:  short_out = a & b;
      OP_OR:   short_out = a | b;
      OP_XOR:  short_out = a ^ b;
      default: begin
        short_out  = '0;
        short_flag = 1'b0;
      end
    endcase
  end

  // One iteration step: MUL keeps {acc, multiplier} and shifts right,
  // DIV keeps {remainder, dividend/quotient} and shifts left
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  // Next iteration values for the shift-add multiplier and restoring divider
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    // Remainder stays below the divisor, so the top bit of the difference is the borrow
    div_ge    = ~div_diff[WIDTH];
    if (op_mul) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else begin
      iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lo = {work_lo[WIDTH-2:0], div_ge};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = is_iter_op ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, iterate in BUSY, result registers hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_mul  <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      work_hi <= '0;
      work_lo <= '0;
      cnt     <= '0;
      out     <= '0;
      out_hi  <= '0;
      flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa     <= a;
            opb     <= b;
            cnt     <= '0;
            work_hi <= '0;
            if (func == OP_MUL) begin
              op_mul  <= 1'b1;
              work_lo <= b;
            end else if (func == OP_DIV) begin
              op_mul  <= 1'b0;
              work_lo <= a;
            end else begin
              out    <= short_out;
              out_hi <= '0;
              flag   <= short_flag;
            end
          end
        end
        BUSY: begin
          work_hi <= iter_hi;
          work_lo <= iter_lo;
          cnt     <= cnt + CW'(1);
          if (last_iter) begin
            if (!op_mul && (opb == '0)) begin
              out    <= '1;
              out_hi <= opa;
              flag   <= 1'b1;
            end else begin
              out    <= iter_lo;
              out_hi <= iter_hi;
              flag   <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu with directed and random operations
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  func = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [31:0] out_hi;
  logic        flag;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(32), .FUNC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .flag(flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's definition
  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] o, output logic [31:0] oh,
                                output logic fl, output int lat);
    logic [63:0] w;
    o = '0; oh = '0; fl = 1'b0; lat = 1;
    case (f)
      6'd0: begin w = 64'(x) + 64'(y); o = w[31:0]; fl = (w > 64'hFFFF_FFFF); end
      6'd1: begin o = x - y; fl = (x < y); end
      6'd2: begin w = 64'(x) * 64'(y); o = w[31:0]; oh = w[63:32]; lat = 33; end
      6'd3: begin
        lat = 33;
        if (y == 0) begin o = 32'hFFFF_FFFF; oh = x; fl = 1'b1; end
        else begin o = x / y; oh = x % y; end
      end
      6'd4: o = x & y;
      6'd5: o = x | y;
      6'd6: o = x ^ y;
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eo, eh;
    logic        ef;
    int          el, lat;
    logic        rdy_bad;
    model(f, x, y, eo, eh, ef, el);
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; func = f; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; func = 6'($urandom); a = $urandom; b = $urandom;
    lat = 1; rdy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(el));
    chk({tag, "_busy_ready"}, 64'(rdy_bad), 64'd0);
    chk({tag, "_out"}, 64'(out), 64'(eo));
    chk({tag, "_out_hi"}, 64'(out_hi), 64'(eh));
    chk({tag, "_flag"}, 64'(flag), 64'(ef));
    @(negedge clk);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_retain"}, {out_hi, out}, {eh, eo});
  endtask

  initial begin
    logic [31:0] ho, hh, eo, eh, x, y;
    logic        ef, stable_bad, rdy_bad, valid_seen;
    logic [5:0]  f;
    int          el, lat;

    // Reset state while rst_n is held low
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", {31'd0, flag, out_hi, out}, 64'd0);

    // Release with a PLUS request waiting: accepted on the first edge
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; func = 6'd0; a = 32'hFFFF_FFFF; b = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("plus_first_valid", 64'(out_valid), 64'd1);
    chk("plus_first_out", 64'(out), 64'd0);
    chk("plus_first_flag", 64'(flag), 64'd1);
    @(negedge clk);
    chk("plus_first_idle", 64'(in_ready), 64'd1);

    run_op("minus", 6'd1, 32'd3, 32'd5);
    run_op("mul", 6'd2, 32'h0001_0000, 32'h0001_0000);
    run_op("div", 6'd3, 32'd100, 32'd7);
    run_op("div0", 6'd3, 32'd5, 32'd0);
    run_op("undef", 6'h3F, 32'hDEAD_BEEF, 32'h1234_5678);
    run_op("mul_max", 6'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_big", 6'd3, 32'hFFFF_FFFF, 32'h0000_0003);

    // Backpressure: result held while in_valid stays high with a new request
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; func = 6'd2; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    model(6'd2, 32'h1234_5678, 32'h9ABC_DEF0, eo, eh, ef, el);
    @(negedge clk);
    x = $urandom; y = $urandom;
    func = 6'd0; a = x; b = y;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("bp_latency", 64'(lat), 64'd33);
    chk("bp_result", {out_hi, out}, {eh, eo});
    ho = out; hh = out_hi; stable_bad = 1'b0; rdy_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out !== ho || out_hi !== hh || out_valid !== 1'b1) stable_bad = 1'b1;
      if (in_ready) rdy_bad = 1'b1;
    end
    chk("bp_stable", 64'(stable_bad), 64'd0);
    chk("bp_no_accept", 64'(rdy_bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    model(6'd0, x, y, eo, eh, ef, el);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_out", {31'd0, flag, out}, {31'd0, ef, eo});
    @(negedge clk);

    // Reset in the middle of a MUL
    run_op("pre_rst", 6'd5, 32'hA5A5_0000, 32'h0000_5A5A);
    @(negedge clk);
    in_valid = 1'b1; func = 6'd2; a = 32'h0000_FFFF; b = 32'h0000_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {31'd0, flag, out_hi, out}, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    valid_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) valid_seen = 1'b1;
    end
    chk("mid_rst_no_stale", 64'(valid_seen), 64'd0);

    // Random operations against the reference model
    for (int n = 0; n < 24; n++) begin
      f = 6'($urandom_range(0, 9));
      if (f > 6'd6) f = 6'($urandom_range(7, 63));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 31);
      if (f == 6'd3 && $urandom_range(0, 5) == 0) y = 32'd0;
      run_op($sformatf("rand%0d_f%0d", n, f), f, x, y);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
